// File: rtl/seg_scan_decoder_if.sv
// Multiplexed 7-segment display bus (all active-low) together with the decoded frame outputs.
interface seg_scan_decoder_if;
    logic [6:0]  sevenSeg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] BCD;
    logic [3:0]  dpPos;
    logic        frameValid;
    logic        frameStable;
    logic        segError;
    logic        anError;
    logic        stale;

    modport master (
        output sevenSeg, dp, an,
        input  BCD, dpPos, frameValid, frameStable, segError, anError, stale
    );

    modport slave (
        input  sevenSeg, dp, an,
        output BCD, dpPos, frameValid, frameStable, segError, anError, stale
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of a scanned 4-digit 7-segment bus: decodes each strobed digit back to hex,
// reassembles frames and tracks frame stability and bus staleness.
module seg_scan_decoder #(
    parameter int unsigned SETTLE        = 1,
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_decoder_if.slave bus
);
    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned DW = SW + 1;
    localparam int unsigned CW = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    // {valid, hex} for a segment pattern (bit6 = a .. bit0 = g, active-low)
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'b0000001: seg_decode = {1'b1, 4'h0};
            7'b1001111: seg_decode = {1'b1, 4'h1};
            7'b0010010: seg_decode = {1'b1, 4'h2};
            7'b0000110: seg_decode = {1'b1, 4'h3};
            7'b1001100: seg_decode = {1'b1, 4'h4};
            7'b0100100: seg_decode = {1'b1, 4'h5};
            7'b0100000: seg_decode = {1'b1, 4'h6};
            7'b0001111: seg_decode = {1'b1, 4'h7};
            7'b0000000: seg_decode = {1'b1, 4'h8};
            7'b0001100: seg_decode = {1'b1, 4'h9};
            7'b0001000: seg_decode = {1'b1, 4'hA};
            7'b1100000: seg_decode = {1'b1, 4'hB};
            7'b0110001: seg_decode = {1'b1, 4'hC};
            7'b1000010: seg_decode = {1'b1, 4'hD};
            7'b0110000: seg_decode = {1'b1, 4'hE};
            7'b0111000: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = 5'h00;
        endcase
    endfunction

    // {valid, digit index}: valid only when exactly one strobe is low
    function automatic logic [2:0] an_decode(input logic [3:0] a);
        case (a)
            4'b1110: an_decode = {1'b1, 2'd0};
            4'b1101: an_decode = {1'b1, 2'd1};
            4'b1011: an_decode = {1'b1, 2'd2};
            4'b0111: an_decode = {1'b1, 2'd3};
            default: an_decode = 3'b000;
        endcase
    endfunction

    logic [11:0]      smp_q, prev_q;
    logic [SW-1:0]    settle_q;
    logic             held_q;
    logic [3:0]       mask_q;
    logic [3:0][3:0]  hex_q;
    logic [3:0]       dps_q;
    logic [15:0]      bcd_q;
    logic [3:0]       dppos_q;
    logic             valid_q, stable_q, seg_err_q, an_err_q, stale_q;
    logic [CW-1:0]    scnt_q;
    logic [IW-1:0]    idle_q;

    logic             changed_c, accept_c, load_c, digit_ok_c;
    logic [DW-1:0]    dwell_c;
    logic [2:0]       an_dec_c;
    logic [4:0]       seg_dec_c;
    logic [CW-1:0]    scnt_next_c;
    logic [IW-1:0]    idle_inc_c;

    always_comb begin
        changed_c   = (smp_q != prev_q);
        dwell_c     = changed_c ? DW'(1) : DW'(settle_q) + DW'(2);
        // held_q blocks a second acceptance within the same dwell
        accept_c    = (changed_c || !held_q) && (dwell_c >= DW'(SETTLE));
        an_dec_c    = an_decode(smp_q[11:8]);
        seg_dec_c   = seg_decode(smp_q[7:1]);
        digit_ok_c  = accept_c && an_dec_c[2] && seg_dec_c[4];
        load_c      = (mask_q == 4'hF);
        scnt_next_c = CW'(1);
        if ({hex_q, dps_q} == {bcd_q, dppos_q})
            scnt_next_c = (scnt_q == CW'(STABLE_FRAMES)) ? scnt_q : scnt_q + CW'(1);
        idle_inc_c  = (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + IW'(1);
    end

    // Input sampling and dwell tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_q    <= '0;
            prev_q   <= '0;
            settle_q <= '0;
            held_q   <= 1'b1;
        end else begin
            smp_q    <= {bus.an, bus.sevenSeg, bus.dp};
            prev_q   <= smp_q;
            held_q   <= accept_c || (held_q && !changed_c);
            if (changed_c)
                settle_q <= '0;
            else if (settle_q != SW'(SETTLE))
                settle_q <= settle_q + SW'(1);
        end
    end

    // Digit holding slots and capture mask; a new digit may land in the mask as it clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            hex_q  <= '0;
            dps_q  <= '0;
        end else begin
            mask_q <= (load_c ? 4'h0 : mask_q) | (digit_ok_c ? (4'(1) << an_dec_c[1:0]) : 4'h0);
            if (digit_ok_c) begin
                hex_q[an_dec_c[1:0]] <= seg_dec_c[3:0];
                dps_q[an_dec_c[1:0]] <= ~smp_q[0];
            end
        end
    end

    // Frame outputs, stability and timeout; a frame load overrides a coincident timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q     <= '0;
            dppos_q   <= '0;
            valid_q   <= 1'b0;
            stable_q  <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            stale_q   <= 1'b0;
            scnt_q    <= '0;
            idle_q    <= '0;
        end else begin
            valid_q   <= load_c;
            seg_err_q <= accept_c && an_dec_c[2] && !seg_dec_c[4];
            an_err_q  <= accept_c && !an_dec_c[2];
            if (load_c) begin
                bcd_q    <= hex_q;
                dppos_q  <= dps_q;
                scnt_q   <= scnt_next_c;
                stable_q <= (scnt_next_c == CW'(STABLE_FRAMES));
                idle_q   <= '0;
                stale_q  <= 1'b0;
            end else begin
                idle_q <= idle_inc_c;
                if (idle_inc_c == IW'(TIMEOUT)) begin
                    stale_q  <= 1'b1;
                    stable_q <= 1'b0;
                    scnt_q   <= '0;
                end
            end
        end
    end

    assign bus.BCD         = bcd_q;
    assign bus.dpPos       = dppos_q;
    assign bus.frameValid  = valid_q;
    assign bus.frameStable = stable_q;
    assign bus.segError    = seg_err_q;
    assign bus.anError     = an_err_q;
    assign bus.stale       = stale_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: random scanned frames checked against a dwell/frame reference
// model through an expected-event scoreboard.
module tb_seg_scan_decoder;
    localparam int SETTLE        = 1;
    localparam int STABLE_FRAMES = 4;
    localparam int TIMEOUT       = 100;

    typedef struct {
        int          cyc;
        bit          fv;
        bit          se;
        bit          ae;
        logic [15:0] bcd;
        logic [3:0]  dpp;
        bit          stable;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .SETTLE(SETTLE), .STABLE_FRAMES(STABLE_FRAMES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [6:0]  seg_tab [16];
    logic [11:0] m_last;
    int          m_run;
    logic [3:0]  m_mask;
    logic [3:0]  m_hex [4];
    logic [3:0]  m_dp;
    logic [19:0] m_prev;
    int          m_cnt;
    int          m_last_f;

    task automatic model_reset();
        m_last = '0;
        m_run  = SETTLE + 1;
        m_mask = '0;
        for (int i = 0; i < 4; i++) m_hex[i] = '0;
        m_dp   = '0;
        m_prev = '0;
        m_cnt  = 0;
    endtask

    task automatic push_evt(input int c, input bit fv, input bit se, input bit ae,
                            input logic [15:0] b, input logic [3:0] d, input bit st);
        exp_t e;
        e.cyc = c; e.fv = fv; e.se = se; e.ae = ae; e.bcd = b; e.dpp = d; e.stable = st;
        q.push_back(e);
    endtask

    // A value accepted in input cycle n reports errors at n+2 and completes a frame at n+3
    task automatic model_accept(input int n, input logic [11:0] v);
        int zeros = 0, digit = 0, hex = -1, f;
        logic [19:0] fr;
        for (int i = 0; i < 4; i++) if (!v[8+i]) begin zeros++; digit = i; end
        if (zeros != 1) begin
            push_evt(n + 2, 0, 0, 1, '0, '0, 0);
            return;
        end
        for (int h = 0; h < 16; h++) if (seg_tab[h] == v[7:1]) hex = h;
        if (hex < 0) begin
            push_evt(n + 2, 0, 1, 0, '0, '0, 0);
            return;
        end
        m_hex[digit]  = 4'(hex);
        m_dp[digit]   = ~v[0];
        m_mask[digit] = 1'b1;
        if (m_mask == 4'hF) begin
            fr = {m_hex[3], m_hex[2], m_hex[1], m_hex[0], m_dp};
            f  = n + 3;
            if (f - m_last_f > TIMEOUT) m_cnt = 0;
            if (fr == m_prev) m_cnt = (m_cnt < STABLE_FRAMES) ? m_cnt + 1 : m_cnt;
            else m_cnt = 1;
            m_prev   = fr;
            m_last_f = f;
            m_mask   = '0;
            push_evt(f, 1, 0, 0, fr[19:4], fr[3:0], m_cnt == STABLE_FRAMES);
        end
    endtask

    task automatic model_step(input int n, input logic [11:0] v);
        if (v != m_last) m_run = 1;
        else if (m_run <= SETTLE) m_run++;
        m_last = v;
        if (m_run == SETTLE) model_accept(n, v);
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic p, input int len);
        for (int k = 0; k < len; k++) begin
            bus.an = a; bus.sevenSeg = s; bus.dp = p;
            model_step(cyc, {a, s, p});
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_digit(input int d, input logic [3:0] hex, input logic dp_on, input int len);
        logic [3:0] a;
        a = ~(4'(1) << d);
        drive(a, seg_tab[hex], ~dp_on, len);
    endtask

    task automatic scan(input logic [15:0] b, input logic [3:0] dpm, input bit shuffle,
                        input int max_dwell, input bit junk);
        int ord[4];
        int j, t;
        logic [11:0] r;
        ord = '{3, 2, 1, 0};
        if (shuffle)
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
        for (int i = 0; i < 4; i++) begin
            if (junk && $urandom_range(0, 7) == 0) begin
                r = 12'($urandom);
                drive(r[11:8], r[7:1], r[0], $urandom_range(1, 2));
            end
            drive_digit(ord[i], b[4*ord[i] +: 4], dpm[ord[i]], $urandom_range(1, max_dwell));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.BCD, bus.dpPos, bus.frameValid, bus.frameStable, bus.segError, bus.anError, bus.stale} !== 25'd0) begin
            errors++;
            $display("FAIL reset_state: got BCD=%h dpPos=%b fv=%b fs=%b se=%b ae=%b stale=%b, want all 0",
                     bus.BCD, bus.dpPos, bus.frameValid, bus.frameStable, bus.segError, bus.anError, bus.stale);
        end
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        m_last_f = cyc;
    endtask

    task automatic check_levels(input string name);
        bit exp_stale, exp_fs;
        exp_stale = (cyc - m_last_f) >= TIMEOUT;
        exp_fs    = !exp_stale && (m_cnt == STABLE_FRAMES);
        checks++;
        if (bus.stale !== exp_stale || bus.frameStable !== exp_fs || bus.BCD !== m_prev[19:4]) begin
            errors++;
            $display("FAIL %s: got stale=%b fs=%b BCD=%h, want stale=%b fs=%b BCD=%h",
                     name, bus.stale, bus.frameStable, bus.BCD, exp_stale, exp_fs, m_prev[19:4]);
        end
    endtask

    // Monitor: pops every expected event due this cycle and compares against the DUT pulses
    exp_t cur, fe;
    bit   e_fv, e_se, e_ae;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            e_fv = 0; e_se = 0; e_ae = 0;
            fe = '{default: 0};
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                cur = q.pop_front();
                if (cur.cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL missed_event: due cycle %0d, now %0d", cur.cyc, cyc);
                end else begin
                    if (cur.fv) begin e_fv = 1; fe = cur; end
                    e_se |= cur.se;
                    e_ae |= cur.ae;
                end
            end
            if (e_fv || e_se || e_ae || bus.frameValid || bus.segError || bus.anError) begin
                checks++;
                if ({bus.frameValid, bus.segError, bus.anError} !== {e_fv, e_se, e_ae}) begin
                    errors++;
                    $display("FAIL pulses cyc=%0d: got fv/se/ae=%b%b%b, want %b%b%b", cyc,
                             bus.frameValid, bus.segError, bus.anError, e_fv, e_se, e_ae);
                end else if (e_fv) begin
                    checks++;
                    if ({bus.BCD, bus.dpPos, bus.frameStable, bus.stale} !== {fe.bcd, fe.dpp, fe.stable, 1'b0}) begin
                        errors++;
                        $display("FAIL frame cyc=%0d: got BCD=%h dpPos=%b fs=%b stale=%b, want BCD=%h dpPos=%b fs=%b stale=0",
                                 cyc, bus.BCD, bus.dpPos, bus.frameStable, bus.stale, fe.bcd, fe.dpp, fe.stable);
                    end
                end
            end
        end
    end

    initial begin
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100; seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0001100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
        bus.an = 4'hF; bus.sevenSeg = 7'h7F; bus.dp = 1'b1;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        drive(4'hF, 7'h7F, 1'b1, 2);

        // 1234 with dp on digit 2, one digit per cycle, until stable
        repeat (5) scan(16'h1234, 4'b0100, 0, 1, 0);

        // reset after two digits of a scan, then four fresh digits
        drive_digit(3, 4'h1, 0, 1);
        drive_digit(2, 4'h2, 1, 1);
        do_reset();
        drive_digit(1, 4'h3, 0, 1);
        drive_digit(0, 4'h4, 0, 1);
        repeat (2) scan(16'h1234, 4'b0100, 0, 1, 0);

        // unmapped pattern on digit 1, then a valid 0 completes the frame
        drive_digit(3, 4'h9, 0, 1);
        drive_digit(2, 4'h8, 0, 1);
        drive_digit(0, 4'h7, 0, 1);
        drive(4'b1101, 7'b1111111, 1'b1, 2);
        drive(4'b1101, 7'b0000001, 1'b1, 1);

        // malformed strobes in distinct dwells
        drive(4'b1111, seg_tab[3], 1'b1, 3);
        drive(4'b1100, seg_tab[3], 1'b1, 3);
        drive(4'b0000, seg_tab[5], 1'b0, 2);

        // steady stream switching value
        repeat (5) scan(16'h1234, 4'b0100, 0, 1, 0);
        repeat (5) scan(16'h5678, 4'b0001, 0, 1, 0);

        // freeze on one strobe past the timeout, then resume
        drive_digit(0, 4'h8, 0, TIMEOUT - 20);
        check_levels("freeze_mid");
        drive_digit(0, 4'h8, 0, 30);
        check_levels("freeze_end");
        repeat (2) scan(16'h5678, 4'b0001, 1, 1, 0);

        // randomized frames, orders, dwell lengths and glitches
        for (int f = 0; f < 40; f++) begin
            logic [15:0] b;
            logic [3:0]  d;
            b = 16'($urandom);
            d = 4'($urandom);
            repeat ($urandom_range(1, 3)) scan(b, d, 1, 3, 1);
        end

        drive(4'hF, 7'h7F, 1'b1, 10);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
